// File: rtl/modadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : modadd_arbiter
// Brief    : Round-robin shared GF(2^255-19) modular add/sub, 2-stage pipeline,
//            responses tagged with the owning requester index.
// Revision : 1.0 - initial release
// ============================================================================
module modadd_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [255*N_REQ-1:0] req_x,
    input  logic [255*N_REQ-1:0] req_y,
    input  logic [N_REQ-1:0]     req_add,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [254:0]         resp_data,
    output logic                 busy
);

    localparam logic [254:0] c_Q = {255{1'b1}} - 255'd18;

    logic [ID_W-1:0]  r_ptr;
    logic             w_grant_found;
    logic [ID_W-1:0]  w_grant_idx;
    int               w_dist;
    int               w_best_dist;
    logic [N_REQ-1:0] w_onehot;
    logic             w_xfer;
    logic [254:0]     w_x;
    logic [254:0]     w_y;
    logic             w_add;

    logic             r_s1_valid;
    logic [254:0]     r_s1_x;
    logic [254:0]     r_s1_y;
    logic             r_s1_add;
    logic [ID_W-1:0]  r_s1_id;

    logic [255:0]     w_sum;
    logic [254:0]     w_sum_red;
    logic [254:0]     w_diff;
    logic [254:0]     w_diff_fix;
    logic [254:0]     w_result;

    // Winner is the valid requester with the smallest rotational distance from r_ptr.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_best_dist   = N_REQ;
        w_dist        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + N_REQ - int'(r_ptr));
            if (req_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist   = w_dist;
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_x      = '0;
        w_y      = '0;
        w_add    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_found && (int'(w_grant_idx) == i)) begin
                w_onehot[i] = 1'b1;
                w_x          = req_x[255*i +: 255];
                w_y          = req_y[255*i +: 255];
                w_add        = req_add[i];
            end
        end
    end

    assign req_ready = rst ? '0 : w_onehot;
    assign w_xfer    = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (int'(w_grant_idx) == N_REQ - 1) ? '0 : (w_grant_idx + ID_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_xfer;
        end
        if (w_xfer) begin
            r_s1_x   <= w_x;
            r_s1_y   <= w_y;
            r_s1_add <= w_add;
            r_s1_id  <= w_grant_idx;
        end
    end

    // 255-bit wraparound makes the corrections exact mod 2^255.
    always_comb begin
        w_sum      = {1'b0, r_s1_x} + {1'b0, r_s1_y};
        w_sum_red  = w_sum[254:0] - c_Q;
        w_diff     = r_s1_x - r_s1_y;
        w_diff_fix = w_diff + c_Q;
        if (r_s1_add) begin
            w_result = (w_sum < {1'b0, c_Q}) ? w_sum[254:0] : w_sum_red;
        end else begin
            w_result = (r_s1_x >= r_s1_y) ? w_diff : w_diff_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                resp_id   <= r_s1_id;
                resp_data <= w_result;
            end
        end
    end

    // Stage 2 only ever holds the final pulse, so stage-1 occupancy is the whole story.
    assign busy = r_s1_valid;

endmodule
`default_nettype wire

// File: tb/tb_modadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_modadd_arbiter
// Brief    : Self-checking bench for modadd_arbiter: directed vectors,
//            contention/pointer/reset sequences and random traffic vs. a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modadd_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam logic [256:0] c_Q = (257'd1 << 255) - 257'd19;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [255*N-1:0] req_x;
    logic [255*N-1:0] req_y;
    logic [N-1:0]     req_add;
    logic             resp_valid;
    logic [IW-1:0]    resp_id;
    logic [254:0]     resp_data;
    logic             busy;

    modadd_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_add(req_add),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        int           id;
        logic [254:0] data;
    } resp_t;

    typedef struct {
        int           idx;
        logic         add;
        logic [254:0] x;
        logic [254:0] y;
        logic [254:0] exp;
    } vec_t;

    resp_t        exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           m_ptr = 0;
    int           m_id  = 0;
    logic [254:0] m_data = '0;
    int           gnt;

    function automatic logic [254:0] f_ref(input logic add, input logic [254:0] x,
                                           input logic [254:0] y);
        logic [256:0] r;
        if (add) r = ({2'b0, x} + {2'b0, y}) % c_Q;
        else     r = ({2'b0, x} + c_Q - {2'b0, y}) % c_Q;
        return r[254:0];
    endfunction

    function automatic logic [254:0] rand_op();
        logic [255:0] v;
        int           sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return 255'd1;
        v = c_Q[255:0] - 256'd1;
        if (sel == 2) return v[254:0];
        do begin
            for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
            v[255] = 1'b0;
        end while (v >= c_Q[255:0]);
        return v[254:0];
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic add, input logic [254:0] x,
                           input logic [254:0] y);
        req_x[255*i +: 255] = x;
        req_y[255*i +: 255] = y;
        req_add[i]          = add;
    endtask

    // One clock cycle: compare DUT against the model, then advance the model.
    task automatic cycle(output int g);
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        logic         exp_rv;
        logic         exp_busy;
        resp_t        e;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        one     = 1;
        exp_rdy = (g >= 0) ? (one << g) : '0;
        chk("req_ready", 256'(req_ready), 256'(exp_rdy));
        exp_rv = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e      = exp_q.pop_front();
            exp_rv = 1'b1;
            m_id   = e.id;
            m_data = e.data;
        end
        chk("resp_valid", 256'(resp_valid), 256'(exp_rv));
        chk("resp_id", 256'(resp_id), 256'(m_id));
        chk("resp_data", 256'(resp_data), 256'(m_data));
        exp_busy = 1'b0;
        foreach (exp_q[k]) if (exp_q[k].due == cyc + 1) exp_busy = 1'b1;
        chk("busy", 256'(busy), 256'(exp_busy));
        if (rst) begin
            exp_q.delete();
            m_ptr  = 0;
            m_id   = 0;
            m_data = '0;
        end else if (g >= 0) begin
            e.due  = cyc + 2;
            e.id   = g;
            e.data = f_ref(req_add[g], req_x[255*g +: 255], req_y[255*g +: 255]);
            exp_q.push_back(e);
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(gnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         tbl[8];
        logic [255:0] t;
        logic [254:0] qm1;
        logic [254:0] qm2;
        logic [N-1:0] pend;

        t   = c_Q[255:0] - 256'd1;
        qm1 = t[254:0];
        t   = c_Q[255:0] - 256'd2;
        qm2 = t[254:0];
        tbl[0] = '{0, 1'b1, qm1,    255'd1, 255'd0};
        tbl[1] = '{0, 1'b1, 255'd5, 255'd7, 255'd12};
        tbl[2] = '{2, 1'b0, 255'd0, 255'd1, qm1};
        tbl[3] = '{2, 1'b0, 255'd9, 255'd4, 255'd5};
        tbl[4] = '{1, 1'b1, qm1,    qm1,    qm2};
        tbl[5] = '{3, 1'b0, qm1,    255'd0, qm1};
        tbl[6] = '{3, 1'b1, 255'd0, 255'd0, 255'd0};
        tbl[7] = '{1, 1'b0, 255'd5, 255'd5, 255'd0};

        // Reset with every requester asserting valid.
        rst       = 1'b1;
        req_valid = '1;
        req_add   = '0;
        req_x     = '0;
        req_y     = '0;
        for (int i = 0; i < N; i++) set_req(i, i[0], rand_op(), rand_op());
        @(posedge clk);
        @(posedge clk);
        #1;
        idle(3);
        rst = 1'b0;

        // Full contention: grants rotate 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            cycle(gnt);
            chk("contention_grant", 256'(gnt), 256'(k % N));
        end
        req_valid = '0;
        idle(3);

        // Pointer: req2 alone, then req1+req3 -> req3 first, then req1.
        req_valid = 4'b0100;
        cycle(gnt);
        req_valid = 4'b1010;
        cycle(gnt);
        chk("ptr_grant_a", 256'(gnt), 256'd3);
        req_valid = 4'b0010;
        cycle(gnt);
        chk("ptr_grant_b", 256'(gnt), 256'd1);
        req_valid = '0;
        idle(3);

        // Directed arithmetic vectors, including wrap and borrow edges.
        foreach (tbl[i]) begin
            set_req(tbl[i].idx, tbl[i].add, tbl[i].x, tbl[i].y);
            req_valid = '0;
            req_valid[tbl[i].idx] = 1'b1;
            cycle(gnt);
            req_valid = '0;
            idle(2);
            chk("vec_data", 256'(resp_data), 256'(tbl[i].exp));
            chk("vec_id", 256'(resp_id), 256'(tbl[i].idx));
        end
        idle(1);

        // Reset one cycle after a transfer discards the op.
        set_req(0, 1'b1, 255'd100, 255'd23);
        req_valid = 4'b0001;
        cycle(gnt);
        req_valid = '0;
        rst = 1'b1;
        cycle(gnt);
        rst = 1'b0;
        idle(2);
        set_req(1, 1'b0, 255'd50, 255'd8);
        req_valid = 4'b0010;
        cycle(gnt);
        chk("post_rst_grant", 256'(gnt), 256'd1);
        req_valid = '0;
        idle(2);
        chk("post_rst_data", 256'(resp_data), 256'd42);
        idle(1);

        // Random traffic with hold-until-granted, withdrawals and sporadic reset.
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'($urandom_range(0, 1)), rand_op(), rand_op());
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            req_valid = pend;
            rst = ($urandom_range(0, 49) == 0);
            cycle(gnt);
            if (gnt >= 0) pend[gnt] = 1'b0;
        end
        rst       = 1'b0;
        req_valid = '0;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modadd_arbiter.md
Name: modadd_arbiter

Overview:
- Shares one GF(2^255−19) modular add/sub datapath (q = 2^255−19) among N_REQ requesters, such as the ladder FSM and the point-op sequencers.
- Round-robin arbitration with a valid/ready request handshake.
- Two-stage pipeline: operand register, then result register.
- Throughput one operation per cycle; every response is tagged with the requester index.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the response ID; must satisfy 2^ID_W ≥ N_REQ.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
- req_x  input  255*N_REQ  flattened operand x; slice i = [255*i+254 : 255*i].
- req_y  input  255*N_REQ  flattened operand y, same slicing.
- req_add  input  N_REQ  1 = x+y mod q, 0 = x−y mod q.
- resp_valid  output  1  result valid (single-cycle pulse per op).
- resp_id  output  ID_W  index of the requester that owns the result.
- resp_data  output  255  modular result.
- busy  output  1  1 while any accepted op has not yet produced resp_valid.

Behaviour:
- Reset: a synchronous rst=1 clears the RR pointer to 0, both pipeline-stage valid bits, resp_valid, resp_id, resp_data, and busy. req_ready is forced to 0 while rst=1.
- Arbitration (combinational, same cycle):
  - grant = first i with req_valid[i]=1, scanning ptr, ptr+1, …, N_REQ−1, 0, …, ptr−1.
  - req_ready = one-hot(grant); all zero if no valid.
  - req_ready never depends on req_x/req_y/req_add.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - The requester must hold valid and operands stable until the transfer.
  - Withdrawing valid before the grant is allowed; that requester simply gets no op.
- Pointer: on a transfer from i, ptr ← (i+1) mod N_REQ. With no transfer, ptr holds.
- Stage 1 (cycle T+1 after a transfer in cycle T): register x, y, add, id; s1_valid=1.
- Stage 2 (cycle T+2): register the datapath output into resp_data with resp_id, and pulse resp_valid=1 for one cycle.
- Latency: exactly 2 cycles from transfer to resp_valid.
- Responses leave in acceptance order; there is no response backpressure.
- No bubbles: back-to-back transfers give back-to-back responses.
- Arithmetic, on stage-1 operands:
  - add: s = x+y as 256 bits. result = s if s < q, else (s − q) truncated to 255 bits.
  - sub: result = x−y if x ≥ y, else (x − y + q) mod 2^255.
  - Operands ≥ q are a caller error. The output is still exactly the formula above (deterministic, not checked).
- resp_data and resp_id hold their last value when resp_valid=0. They are 0 after reset until the first result.
- busy = s1_valid | (stage-2 occupancy excluding the final pulse cycle). Equivalently: busy=1 from T+1 through T+1 of the last accepted op, and 0 in the cycle resp_valid of the last op is high.
- Reset mid-operation: in-flight ops are discarded; no resp_valid is generated for them, and the pointer returns to 0.
- A request presented during rst is not accepted.
- Simultaneous valids: exactly one grant per cycle. A continuously-valid requester waits at most N_REQ−1 cycles.

Test Plan:
- Reset: hold rst 3 cycles with all req_valid=1 → req_ready=0, resp_valid=0, resp_data=0, busy=0. After release, the first grant goes to requester 0.
- Add wrap: req0 add, x=q−1, y=1, transfer at T → resp_valid at T+2, resp_id=0, resp_data=0. Also x=5, y=7 → 12.
- Sub borrow: req2 sub, x=0, y=1 → resp_data = q−1 = 2^255−20, resp_id=2. Also x=9, y=4 → 5.
- Full contention: all 4 valid every cycle for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles; 8 consecutive resp_valid pulses with ids in the same order; busy continuous.
- Pointer: only req2 valid (granted, ptr=3); next cycle req1 and req3 valid → req3 granted first, then req1 on the following cycle.
- Reset mid-flight: transfer at T, rst=1 at T+1 → no resp_valid at T+2 or T+3, busy=0. After rst deasserts, a new op from req1 completes normally in 2 cycles.
